// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller on the RIB bus.
// Latches NUM_SRC interrupt lines through a per-source edge/level gateway,
// masks them with a per-source enable, and offers a fixed-priority
// claim/complete protocol. Source i has ID i+1; ID 0 means "none".
// Register map (addr_i[7:2]): 0 PENDING, 1 ENABLE, 2 EDGE, 3 CLAIM/COMPLETE,
// 4 IN_SERVICE; anything else reads 0 and ignores writes.
module irq_ctrl #(
   parameter int NUM_SRC = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        data_i,
   output logic [31:0]        data_o,
   output logic               ready_o,
   input  logic [NUM_SRC-1:0] src_i,
   output logic               irq_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   localparam logic [5:0] IDX_PENDING = 6'h00;
   localparam logic [5:0] IDX_ENABLE  = 6'h01;
   localparam logic [5:0] IDX_EDGE    = 6'h02;
   localparam logic [5:0] IDX_CLAIM   = 6'h03;
   localparam logic [5:0] IDX_INSVC   = 6'h04;
   localparam int         PAD_W       = 32 - NUM_SRC;

   // Architectural state
   state_t             r_state;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_edge;
   logic [NUM_SRC-1:0] r_in_service;
   logic [NUM_SRC-1:0] r_src_q;
   logic [31:0]        r_data;
   logic               r_ready;
   logic               r_irq;

   // Combinational next-state and decode
   state_t             w_state_next;
   logic               w_access;
   logic               w_rd;
   logic               w_wr;
   logic [5:0]         w_reg_idx;
   logic               w_claim_rd;
   logic               w_complete_wr;
   logic [4:0]         w_claim_id;
   logic [31:0]        w_rd_data;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_gw_set;
   logic [NUM_SRC-1:0] w_claim_clr;
   logic [NUM_SRC-1:0] w_complete_clr;
   logic [NUM_SRC-1:0] w_pending_next;
   logic [NUM_SRC-1:0] w_enable_next;
   logic [NUM_SRC-1:0] w_edge_next;
   logic [NUM_SRC-1:0] w_in_service_next;
   logic               w_irq_next;

   // Address bits outside [7:2] and the high data bits are deliberately ignored.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, addr_i[31:8], addr_i[1:0], data_i};

   assign w_reg_idx     = addr_i[7:2];
   assign w_rd          = w_access & ~we_i;
   assign w_wr          = w_access &  we_i;
   assign w_claim_rd    = w_rd & (w_reg_idx == IDX_CLAIM);
   assign w_complete_wr = w_wr & (w_reg_idx == IDX_CLAIM);
   assign w_eligible    = r_pending & r_enable & ~r_in_service;

   // Bus FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Bus FSM next state: accept a request in IDLE, spend one cycle in RESP
   always_comb begin
      w_state_next = r_state;
      w_access     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_i) begin
               w_access     = 1'b1;
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Fixed priority: the lowest-index eligible source wins the claim
   always_comb begin
      w_claim_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_claim_id = 5'(i + 1);
         end
      end
   end

   // Per-source gateway plus claim/complete one-hot decode
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      localparam logic [4:0] SRC_ID = 5'(gi + 1);

      // Edge mode fires on 0->1; level mode fires while high and not in service.
      assign w_gw_set[gi] = r_edge[gi] ? (src_i[gi] & ~r_src_q[gi])
                                       : (src_i[gi] & ~r_in_service[gi]);
      // ID 0 never matches, so an empty claim touches nothing.
      assign w_claim_clr[gi] = w_claim_rd & (w_claim_id == SRC_ID);
      // Out-of-range IDs match no source; clearing an idle bit is a no-op.
      assign w_complete_clr[gi] = w_complete_wr & (data_i[4:0] == SRC_ID);
   end

   // A gateway set in the claim cycle outranks the claim clear.
   assign w_pending_next    = (r_pending & ~w_claim_clr) | w_gw_set;
   assign w_in_service_next = (r_in_service | w_claim_clr) & ~w_complete_clr;
   assign w_enable_next     = (w_wr && w_reg_idx == IDX_ENABLE) ? data_i[NUM_SRC-1:0] : r_enable;
   assign w_edge_next       = (w_wr && w_reg_idx == IDX_EDGE)   ? data_i[NUM_SRC-1:0] : r_edge;
   assign w_irq_next        = |(w_pending_next & w_enable_next & ~w_in_service_next);

   // Read multiplexer; narrow registers are zero-extended to 32 bits
   always_comb begin
      w_rd_data = '0;
      case (w_reg_idx)
         IDX_PENDING: w_rd_data = {{PAD_W{1'b0}}, r_pending};
         IDX_ENABLE:  w_rd_data = {{PAD_W{1'b0}}, r_enable};
         IDX_EDGE:    w_rd_data = {{PAD_W{1'b0}}, r_edge};
         IDX_CLAIM:   w_rd_data = {27'd0, w_claim_id};
         IDX_INSVC:   w_rd_data = {{PAD_W{1'b0}}, r_in_service};
         default:     w_rd_data = '0;
      endcase
   end

   // Interrupt state, response registers and registered irq
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pending    <= '0;
         r_enable     <= '0;
         r_edge       <= '0;
         r_in_service <= '0;
         r_src_q      <= '0;
         r_data       <= '0;
         r_ready      <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         r_pending    <= w_pending_next;
         r_enable     <= w_enable_next;
         r_edge       <= w_edge_next;
         r_in_service <= w_in_service_next;
         r_src_q      <= src_i;
         r_ready      <= w_access;
         r_irq        <= w_irq_next;
         if (w_rd) begin
            r_data <= w_rd_data;
         end
      end
   end

   assign data_o  = r_data;
   assign ready_o = r_ready;
   assign irq_o   = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed walk through the claim/complete scenarios followed
// by a random phase, all compared cycle by cycle against a behavioural model
// of the register map and gateway rules.
module tb_irq_ctrl;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   data_o;
   logic          ready_o;
   logic [N-1:0]  src = '0;
   logic          irq;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [N-1:0] m_pend = '0;
   logic [N-1:0] m_en = '0;
   logic [N-1:0] m_edge = '0;
   logic [N-1:0] m_isv = '0;
   logic [N-1:0] m_srcq = '0;
   logic [31:0]  m_data = '0;
   bit           m_ready = 1'b0;
   bit           m_resp = 1'b0;
   bit           m_irq = 1'b0;

   irq_ctrl #(.NUM_SRC(N)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .data_i  (wdata),
      .data_o  (data_o),
      .ready_o (ready_o),
      .src_i   (src),
      .irq_o   (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock: model computes its next state from the inputs
   // presented this cycle, then DUT outputs are compared 1 ns after the edge.
   task automatic tick();
      logic [N-1:0] n_pend, n_en, n_edge, n_isv, clr, set;
      logic [31:0]  n_data;
      bit           acc;
      int           id, idx;
      n_pend = m_pend; n_en = m_en; n_edge = m_edge; n_isv = m_isv;
      n_data = m_data; clr = '0; set = '0;
      acc = req && !m_resp;
      if (acc) begin
         idx = int'(addr[7:2]);
         if (!we) begin
            case (idx)
               0: n_data = 32'(m_pend);
               1: n_data = 32'(m_en);
               2: n_data = 32'(m_edge);
               3: begin
                  id = 0;
                  for (int i = 0; i < N; i++)
                     if (id == 0 && m_pend[i] && m_en[i] && !m_isv[i]) id = i + 1;
                  n_data = 32'(id);
                  if (id != 0) begin
                     clr[id-1]   = 1'b1;
                     n_isv[id-1] = 1'b1;
                  end
               end
               4: n_data = 32'(m_isv);
               default: n_data = 32'd0;
            endcase
         end else begin
            case (idx)
               1: n_en = wdata[N-1:0];
               2: n_edge = wdata[N-1:0];
               3: begin
                  id = int'(wdata[4:0]);
                  if (id >= 1 && id <= N) n_isv[id-1] = 1'b0;
               end
               default: ;
            endcase
         end
      end
      for (int i = 0; i < N; i++) begin
         if (m_edge[i]) set[i] = src[i] && !m_srcq[i];
         else           set[i] = src[i] && !m_isv[i];
      end
      n_pend = (m_pend & ~clr) | set;
      @(posedge clk);
      if (rst) begin
         m_pend = '0; m_en = '0; m_edge = '0; m_isv = '0; m_srcq = '0;
         m_data = '0; m_ready = 1'b0; m_resp = 1'b0; m_irq = 1'b0;
      end else begin
         m_pend = n_pend; m_en = n_en; m_edge = n_edge; m_isv = n_isv;
         m_srcq = src; m_data = n_data; m_ready = acc; m_resp = acc;
         m_irq = |(n_pend & n_en & ~n_isv);
      end
      #1;
      chk("irq_o", irq, m_irq);
      chk("ready_o", ready_o, m_ready);
      chk("data_o", data_o, m_data);
   endtask

   // One bus transaction: request, response cycle, release
   task automatic bus(input bit w, input logic [7:0] ofs, input logic [31:0] d,
                      output logic [31:0] rd);
      logic [31:0] r;
      r = $urandom;
      req = 1'b1; we = w; addr = {r[31:8], ofs[7:2], r[1:0]}; wdata = d;
      tick();
      rd = data_o;
      req = 1'b0;
      tick();
      $display("bus %s ofs=%02h wdata=%08h rdata=%08h src=%02h irq=%0b",
               w ? "WR" : "RD", ofs, d, rd, src, irq);
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  ofs_tab [6];
      logic [7:0]  ofs;
      ofs_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20};

      // Reset and empty reads
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_irq", irq, 0);
      bus(0, 8'h00, 0, rd); chk("reset_pending", rd, 0);
      bus(0, 8'h04, 0, rd); chk("reset_enable", rd, 0);
      bus(0, 8'h0C, 0, rd); chk("reset_claim", rd, 0);

      // Level source 1 (ID 2): claim, complete with line still high
      bus(1, 8'h04, 32'h03, rd);
      bus(1, 8'h08, 32'h00, rd);
      src = 8'h02;
      tick(); tick();
      chk("level_irq_up", irq, 1);
      bus(0, 8'h0C, 0, rd); chk("level_claim", rd, 2);
      chk("level_irq_after_claim", irq, 0);
      bus(0, 8'h10, 0, rd); chk("level_insvc", rd, 32'h02);
      bus(1, 8'h0C, 2, rd);
      bus(0, 8'h00, 0, rd); chk("level_repend", rd, 32'h02);
      chk("level_irq_again", irq, 1);
      src = 8'h00;
      bus(0, 8'h0C, 0, rd); chk("level_claim2", rd, 2);
      bus(1, 8'h0C, 2, rd);

      // Priority between two simultaneous sources
      src = 8'h09;
      tick();
      src = 8'h00;
      bus(1, 8'h04, 32'h09, rd);
      bus(0, 8'h0C, 0, rd); chk("prio_first", rd, 1);
      bus(0, 8'h0C, 0, rd); chk("prio_second", rd, 4);
      bus(0, 8'h0C, 0, rd); chk("prio_none", rd, 0);
      bus(1, 8'h0C, 1, rd);
      bus(1, 8'h0C, 4, rd);

      // Edge mode: held line pends once; re-edge while in service
      bus(1, 8'h08, 32'h01, rd);
      bus(1, 8'h04, 32'h01, rd);
      src = 8'h01;
      repeat (10) tick();
      src = 8'h00;
      tick();
      bus(0, 8'h0C, 0, rd); chk("edge_claim", rd, 1);
      bus(0, 8'h00, 0, rd); chk("edge_single_pend", rd, 0);
      src = 8'h01; tick();
      src = 8'h00; tick();
      bus(0, 8'h00, 0, rd); chk("edge_repend_in_service", rd, 32'h01);
      chk("edge_irq_blocked", irq, 0);

      // Ignored completes and unmapped offset
      bus(1, 8'h0C, 0, rd);
      bus(1, 8'h0C, 9, rd);
      bus(1, 8'h0C, 3, rd);
      bus(0, 8'h10, 0, rd); chk("bad_complete_insvc", rd, 32'h01);
      bus(0, 8'h20, 0, rd); chk("unmapped_read", rd, 0);
      bus(1, 8'h0C, 1, rd);
      chk("edge_irq_after_complete", irq, 1);

      // Rising edge in the same cycle as the claim access: set wins
      bus(0, 8'h0C, 0, rd);
      bus(1, 8'h0C, 1, rd);
      src = 8'h01; tick();
      src = 8'h00; tick();
      req = 1'b1; we = 1'b0; addr = 32'h0000_000C; src = 8'h01;
      tick();
      chk("collide_claim", data_o, 1);
      req = 1'b0; src = 8'h00;
      tick();
      bus(0, 8'h00, 0, rd); chk("collide_pend_kept", rd, 32'h01);

      // Reset while the bus is in RESP
      req = 1'b1; we = 1'b1; addr = 32'h0000_0004; wdata = 32'hFF;
      tick();
      req = 1'b0; rst = 1'b1;
      tick();
      chk("rst_resp_ready", ready_o, 0);
      rst = 1'b0;
      tick();
      bus(0, 8'h04, 0, rd); chk("rst_enable", rd, 0);
      bus(0, 8'h00, 0, rd); chk("rst_pending", rd, 0);
      bus(0, 8'h10, 0, rd); chk("rst_insvc", rd, 0);

      // Random phase against the model
      for (int k = 0; k < 300; k++) begin
         src = 8'($urandom & $urandom);
         case ($urandom_range(0, 11))
            0: repeat ($urandom_range(1, 3)) tick();
            1: begin
               rst = 1'b1; tick(); rst = 1'b0;
            end
            default: begin
               ofs = ofs_tab[$urandom_range(0, 5)];
               if (ofs == 8'h0C && $urandom_range(0, 1) == 1)
                  bus(1, ofs, 32'($urandom_range(0, 10)), rd);
               else
                  bus(1'($urandom_range(0, 1)), ofs, $urandom, rd);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
